bilbo_bist_controller: RTL

Built-in self-test sequencer for the BILBO adder system (registers A, B, C around a 4-bit adder).
- Normal operation: drives B1/B2 to Normal mode and forwards host load strobes.
- On Start: clears the BILBO registers, serially loads a seed through Si, runs a programmable number of test clocks, then scans the full 3N+1-bit chain back out through So, compares it to a golden signature and reports pass/fail.

---
 rtl/bilbo_bist_controller.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/bilbo_bist_controller.sv
// rtl/bilbo_bist_controller.sv - BIST sequencer for the BILBO adder system
module bilbo_bist_controller #(
    parameter int         N           = 4,
    parameter logic [1:0] MODE_NORMAL = 2'b11,
    parameter logic [1:0] MODE_SHIFT  = 2'b00,
    parameter logic [1:0] MODE_TEST   = 2'b01,
    parameter logic [1:0] MODE_CLEAR  = 2'b10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       cycles,
    input  logic [3*N:0]     seed,
    input  logic [3*N:0]     golden,
    input  logic             host_ld_a,
    input  logic             host_ld_b,
    input  logic             host_ld_c,
    input  logic             so,
    output logic             b1,
    output logic             b2,
    output logic             ld_a,
    output logic             ld_b,
    output logic             ld_c,
    output logic             si,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [3*N:0]     signature
);
    localparam int         L    = 3 * N + 1;
    localparam logic [7:0] LAST = 8'(L - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SEED,
        S_RUN,
        S_UNLOAD,
        S_CHECK
    } state_t;

    state_t       state;
    logic [7:0]   cnt;
    logic [7:0]   cycles_q;
    logic [L-1:0] seed_q;
    logic [L-1:0] golden_q;
    logic [1:0]   mode;
    logic [L-1:0] sig_next;

    assign {b1, b2} = mode;
    assign ld_a     = (state == S_IDLE) & host_ld_a;
    assign ld_b     = (state == S_IDLE) & host_ld_b;
    assign ld_c     = (state == S_IDLE) & host_ld_c;
    assign sig_next = {signature[L-2:0], so};

    // cnt holds the number of edges left in the current phase minus one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            cycles_q  <= '0;
            seed_q    <= '0;
            golden_q  <= '0;
            mode      <= MODE_NORMAL;
            si        <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            signature <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state     <= S_CLEAR;
                        mode      <= MODE_CLEAR;
                        busy      <= 1'b1;
                        seed_q    <= seed;
                        golden_q  <= golden;
                        cycles_q  <= cycles;
                        pass      <= 1'b0;
                        signature <= '0;
                    end
                end
                S_CLEAR: begin
                    state  <= S_SEED;
                    mode   <= MODE_SHIFT;
                    si     <= seed_q[L-1];
                    seed_q <= {seed_q[L-2:0], 1'b0};
                    cnt    <= LAST;
                end
                S_SEED: begin
                    if (cnt == 8'd0) begin
                        si <= 1'b0;
                        if (cycles_q != 8'd0) begin
                            state <= S_RUN;
                            mode  <= MODE_TEST;
                            cnt   <= cycles_q - 8'd1;
                        end else begin
                            state <= S_UNLOAD;
                            mode  <= MODE_SHIFT;
                            cnt   <= LAST;
                        end
                    end else begin
                        si     <= seed_q[L-1];
                        seed_q <= {seed_q[L-2:0], 1'b0};
                        cnt    <= cnt - 8'd1;
                    end
                end
                S_RUN: begin
                    if (cnt == 8'd0) begin
                        state <= S_UNLOAD;
                        mode  <= MODE_SHIFT;
                        cnt   <= LAST;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                S_UNLOAD: begin
                    signature <= sig_next;
                    if (cnt == 8'd0) begin
                        // Pass is resolved together with the last bit so it is valid while done is high
                        state <= S_CHECK;
                        mode  <= MODE_NORMAL;
                        done  <= 1'b1;
                        pass  <= (sig_next == golden_q);
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                S_CHECK: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
